draw_line_gen: RTL and testbench
================================

Name: draw_line_gen

Overview:
Parametrised successor to the draw_line rasteriser. Takes a start point plus signed x/y lengths and emits every pixel of the line, inclusive of both endpoints, as a stream of (x, y, colour) writes to the display SRAM writer. Adds the following over the fixed-width engine:
- generic coordinate and length widths
- valid/ready backpressure on the write port
- screen-bounds clipping
- an 8-bit dash pattern
- a colour field
- abort

Sits between the command decoder and the frame-buffer write arbiter.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
LEN_W, 9, signed length width (two's complement)
SCREEN_W, 160, visible columns; x >= SCREEN_W is off-screen
SCREEN_H, 120, visible rows; y >= SCREEN_H is off-screen
COLOR_W, 1, pixel colour width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_x_pos  in  X_W  line start x (unsigned)
start_y_pos  in  Y_W  line start y (unsigned)
x_length  in  LEN_W  signed dx
y_length  in  LEN_W  signed dy
color  in  COLOR_W  pixel colour
dash_pattern  in  8  per-step emit mask; 8'hFF = solid
start_line  in  1  command strobe
abort  in  1  cancel current line
wr_valid  out  1  pixel write valid
wr_ready  in  1  writer accepts pixel
write_x_pos  out  X_W  pixel x
write_y_pos  out  Y_W  pixel y
write_color  out  COLOR_W  pixel colour
running  out  1  engine busy
done  out  1  one-cycle pulse on line completion (not on abort)

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). When rst_n is low, all outputs are 0, state is IDLE, and internal registers are cleared. Reset mid-line discards the line and emits no further writes.
- States: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - start_line=1 latches all inputs, moves to SETUP.
  - running=1 from the next cycle.
  - start_line while running=1 is ignored.
- SETUP (1 cycle):
  - ax=|dx|, ay=|dy|, sx/sy = direction signs.
  - steps = max(ax,ay)+1.
  - err = ax-ay, signed LEN_W+2 bits.
  - Current point held signed, X_W+2 / Y_W+2 bits.
  - Goes to DRAW.
- DRAW, per step k (0..steps-1):
  - Point is emitted iff dash_pattern[k mod 8]=1 and 0<=x<SCREEN_W and 0<=y<SCREEN_H.
  - Emitted point: wr_valid=1 with outputs stable until wr_ready=1. The step advances on the cycle where wr_valid&&wr_ready.
  - Non-emitted point: consumes one cycle with wr_valid=0, then advances.
  - Bresenham update on advance, with e2=2*err:
    - if e2 > -ay: err-=ay, x+=sx
    - if e2 < ax: err+=ax, y+=sy
  - After step steps-1 advances, go to DONE.
- Latency: start accepted at cycle N gives the first wr_valid at N+2. Sustained throughput is 1 pixel/cycle with wr_ready=1.
- DONE (1 cycle): done=1, running=0 from the next cycle, return to IDLE. A start_line arriving in DONE is accepted on the following IDLE cycle only.
- abort: in any non-IDLE state, go to IDLE next cycle. wr_valid drops immediately (the one permitted break of stability), running=0, no done pulse. abort in IDLE has no effect. abort and start_line together in IDLE: start wins.
- Zero length (dx=dy=0): exactly one step, i.e. a single point.
- Lengths at LEN_W extremes (e.g. -256) must not overflow: abs is computed in LEN_W+1 bits.
- Intermediate coordinates may go negative or exceed the screen; clipped points are stepped, never wrapped.
- write_x_pos / write_y_pos are the low X_W/Y_W bits of the on-screen point only.

Decomposition:
- Package draw_pkg holds:
  - line_state_e enum (IDLE, SETUP, DRAW, DONE)
  - default SCREEN_W/SCREEN_H localparams
  - a pixel_t struct (x, y, color) for the write port
- Single module; no sub-module. Clip and dash qualification are combinational inside draw_line_gen.

Test Plan:
- (28,7), dx=20, dy=17, solid, wr_ready=1: 21 writes, first (28,7), last (48,24), exactly one step in x per write, done 1 cycle after the last accept, running low next.
- (12,15), dx=10, dy=-4: 11 writes from (12,15) to (22,11), y monotonically non-increasing.
- (150,100), dx=20, dy=0: writes x=150..159 only (10 writes), 21 DRAW cycles, done asserted.
- (0,0), dx=15, dy=0, dash_pattern=8'b0000_1111: writes x=0..3 and x=8..11 only.
- Line 1 with wr_ready pseudo-random (~50%): the same 21 points in order, with outputs held stable while wr_valid&&!wr_ready.
- Boundary and control cases:
  - dx=dy=0 at (5,5) gives 1 write at (5,5).
  - abort mid-line gives no done and wr_valid=0 next cycle.
  - rst_n low mid-line clears all outputs asynchronously.
  - start_line while running is ignored.

Source files
------------

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared state encoding, default screen geometry and write-port record for draw_line_gen
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } line_state_e;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOR_W  = 1;

  // Pixel write record at the default frame-buffer geometry.
  typedef struct packed {
    logic [DEF_X_W-1:0]     x;
    logic [DEF_Y_W-1:0]     y;
    logic [DEF_COLOR_W-1:0] color;
  } pixel_t;

endpackage

// File: rtl/draw_line_gen.sv
// rtl/draw_line_gen.sv - Bresenham line rasteriser with dash mask, screen clipping, backpressure and abort
module draw_line_gen
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int LEN_W    = 9,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int COLOR_W  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_W-1:0]     start_x_pos,
  input  logic [Y_W-1:0]     start_y_pos,
  input  logic [LEN_W-1:0]   x_length,
  input  logic [LEN_W-1:0]   y_length,
  input  logic [COLOR_W-1:0] color,
  input  logic [7:0]         dash_pattern,
  input  logic               start_line,
  input  logic               abort,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [X_W-1:0]     write_x_pos,
  output logic [Y_W-1:0]     write_y_pos,
  output logic [COLOR_W-1:0] write_color,
  output logic               running,
  output logic               done
);

  localparam int XS_W = X_W + 2;
  localparam int YS_W = Y_W + 2;
  localparam int ER_W = LEN_W + 2;
  localparam logic signed [XS_W-1:0] X_LIM = XS_W'(SCREEN_W);
  localparam logic signed [YS_W-1:0] Y_LIM = YS_W'(SCREEN_H);
  localparam logic signed [XS_W-1:0] X_ONE = XS_W'(1);
  localparam logic signed [YS_W-1:0] Y_ONE = YS_W'(1);
  localparam logic [LEN_W:0]         K_ONE = (LEN_W+1)'(1);

  line_state_e              state_q, state_d;
  logic signed [LEN_W-1:0]  dx_q, dx_d, dy_q, dy_d;
  logic [COLOR_W-1:0]       color_q, color_d;
  logic [7:0]               dash_q, dash_d;
  logic [LEN_W:0]           ax_q, ax_d, ay_q, ay_d;
  logic [LEN_W:0]           kmax_q, kmax_d, k_q, k_d;
  logic                     sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [ER_W-1:0]   err_q, err_d;
  logic signed [XS_W-1:0]   cur_x_q, cur_x_d;
  logic signed [YS_W-1:0]   cur_y_q, cur_y_d;

  // Lengths widened by one bit so that |most negative| is representable.
  logic signed [LEN_W:0]    dx_ext, dy_ext;
  logic [LEN_W:0]           ax_c, ay_c;
  logic signed [ER_W:0]     e2, ax_s, ay_s;
  logic signed [ER_W-1:0]   ax_e, ay_e;
  logic                     step_x, step_y, on_screen, emit, advance, last;

  assign dx_ext = {dx_q[LEN_W-1], dx_q};
  assign dy_ext = {dy_q[LEN_W-1], dy_q};
  assign ax_c   = dx_q[LEN_W-1] ? -dx_ext : dx_ext;
  assign ay_c   = dy_q[LEN_W-1] ? -dy_ext : dy_ext;

  assign e2     = {err_q, 1'b0};
  assign ax_s   = {2'b00, ax_q};
  assign ay_s   = {2'b00, ay_q};
  assign ax_e   = {1'b0, ax_q};
  assign ay_e   = {1'b0, ay_q};
  assign step_x = e2 > -ay_s;
  assign step_y = e2 < ax_s;

  assign on_screen = !cur_x_q[XS_W-1] && (cur_x_q < X_LIM) &&
                     !cur_y_q[YS_W-1] && (cur_y_q < Y_LIM);
  assign emit      = (state_q == DRAW) && dash_q[k_q[2:0]] && on_screen;
  assign advance   = !emit || wr_ready;
  assign last      = (k_q == kmax_q);

  // Abort withdraws the request in the same cycle; nothing else breaks hold.
  assign wr_valid    = emit && !abort;
  assign write_x_pos = emit ? cur_x_q[X_W-1:0] : '0;
  assign write_y_pos = emit ? cur_y_q[Y_W-1:0] : '0;
  assign write_color = emit ? color_q : '0;
  assign running     = (state_q != IDLE);
  assign done        = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    color_d  = color_q;
    dash_d   = dash_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    kmax_d   = kmax_q;
    k_d      = k_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_d    = err_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    case (state_q)
      IDLE: begin
        if (start_line) begin
          state_d = SETUP;
          dx_d    = x_length;
          dy_d    = y_length;
          color_d = color;
          dash_d  = dash_pattern;
          cur_x_d = {2'b00, start_x_pos};
          cur_y_d = {2'b00, start_y_pos};
        end
      end
      SETUP: begin
        ax_d     = ax_c;
        ay_d     = ay_c;
        sx_neg_d = dx_q[LEN_W-1];
        sy_neg_d = dy_q[LEN_W-1];
        kmax_d   = (ax_c > ay_c) ? ax_c : ay_c;
        k_d      = '0;
        err_d    = $signed({1'b0, ax_c}) - $signed({1'b0, ay_c});
        state_d  = abort ? IDLE : DRAW;
      end
      DRAW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (advance) begin
          if (step_x) begin
            cur_x_d = sx_neg_q ? cur_x_q - X_ONE : cur_x_q + X_ONE;
          end
          if (step_y) begin
            cur_y_d = sy_neg_q ? cur_y_q - Y_ONE : cur_y_q + Y_ONE;
          end
          err_d = err_q - (step_x ? ay_e : '0) + (step_y ? ax_e : '0);
          k_d   = k_q + K_ONE;
          if (last) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dx_q     <= '0;
      dy_q     <= '0;
      color_q  <= '0;
      dash_q   <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      kmax_q   <= '0;
      k_q      <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      color_q  <= color_d;
      dash_q   <= dash_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      kmax_q   <= kmax_d;
      k_q      <= k_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      err_q    <= err_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
    end
  end

endmodule

// File: tb/tb_draw_line_gen.sv
// tb/tb_draw_line_gen.sv - randomized self-checking bench for draw_line_gen against an integer line model
module tb_draw_line_gen;
  import draw_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] start_x_pos = '0;
  logic [6:0] start_y_pos = '0;
  logic [8:0] x_length = '0;
  logic [8:0] y_length = '0;
  logic [0:0] color = '0;
  logic [7:0] dash_pattern = 8'hFF;
  logic       start_line = 1'b0;
  logic       abort = 1'b0;
  logic       wr_valid;
  logic       wr_ready = 1'b1;
  logic [7:0] write_x_pos;
  logic [6:0] write_y_pos;
  logic [0:0] write_color;
  logic       running;
  logic       done;

  int     n_checks = 0;
  int     n_fail = 0;
  bit     rnd_ready = 0;
  pixel_t exp_q[$];
  pixel_t got_q[$];
  int     m_steps;
  int     m_first;

  draw_line_gen dut (
    .clk(clk), .rst_n(rst_n),
    .start_x_pos(start_x_pos), .start_y_pos(start_y_pos),
    .x_length(x_length), .y_length(y_length),
    .color(color), .dash_pattern(dash_pattern),
    .start_line(start_line), .abort(abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .write_x_pos(write_x_pos), .write_y_pos(write_y_pos),
    .write_color(write_color), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the line with plain integers, keep dashed, on-screen points.
  task automatic model(input int x0, input int y0, input int dx, input int dy,
                       input logic [7:0] dash, input logic [0:0] col);
    int ax, ay, sx, sy, err, e2, x, y;
    pixel_t p;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    sx = (dx < 0) ? -1 : 1;
    sy = (dy < 0) ? -1 : 1;
    err = ax - ay;
    x = x0;
    y = y0;
    m_steps = ((ax > ay) ? ax : ay) + 1;
    m_first = -1;
    exp_q.delete();
    for (int k = 0; k < m_steps; k++) begin
      if (dash[k % 8] && x >= 0 && x < DEF_SCREEN_W && y >= 0 && y < DEF_SCREEN_H) begin
        p.x = 8'(x);
        p.y = 7'(y);
        p.color = col;
        exp_q.push_back(p);
        if (m_first < 0) m_first = k;
      end
      e2 = 2 * err;
      if (e2 > -ay) begin err -= ay; x += sx; end
      if (e2 < ax)  begin err += ax; y += sy; end
    end
  endtask

  task automatic launch(input int x0, input int y0, input int dx, input int dy,
                        input logic [7:0] dash, input logic [0:0] col);
    model(x0, y0, dx, dy, dash, col);
    got_q.delete();
    @(posedge clk); #1;
    start_x_pos  = 8'(x0);
    start_y_pos  = 7'(y0);
    x_length     = 9'(dx);
    y_length     = 9'(dy);
    dash_pattern = dash;
    color        = col;
    start_line   = 1'b1;
    @(posedge clk); #1;
    start_line   = 1'b0;
  endtask

  task automatic finish_line(input bit extra_start);
    bit seen;
    int stalls, first_v, done_i;
    seen = 0; stalls = 0; first_v = -1; done_i = 0;
    for (int i = 1; i <= 3000 && !seen; i++) begin
      @(negedge clk);
      if (extra_start && i == 3) begin
        start_x_pos = 8'd100; x_length = 9'd30; start_line = 1'b1;
      end
      if (extra_start && i == 4) start_line = 1'b0;
      if (wr_valid && first_v < 0) first_v = i;
      if (wr_valid && !wr_ready) stalls++;
      if (done) begin seen = 1; done_i = i; end
    end
    chk("done seen", int'(seen), 1);
    if (seen) begin
      chk("done cycle", done_i, m_steps + stalls + 2);
      if (m_first >= 0) chk("first valid cycle", first_v, m_first + 2);
      chk("all points written", exp_q.size(), 0);
      @(negedge clk);
      chk("running after done", int'(running), 0);
      chk("done one cycle", int'(done), 0);
    end
  endtask

  task automatic run_line(input int x0, input int y0, input int dx, input int dy,
                          input logic [7:0] dash, input logic [0:0] col);
    launch(x0, y0, dx, dy, dash, col);
    finish_line(0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Data checker: every accepted write must be the next modelled point.
  initial begin
    bit prev_stall;
    pixel_t held, e;
    prev_stall = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (wr_valid) begin
        if (prev_stall) begin
          chk("hold x", int'(write_x_pos), int'(held.x));
          chk("hold y", int'(write_y_pos), int'(held.y));
          chk("hold color", int'(write_color), int'(held.color));
        end
        if (wr_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra write: got (%0d,%0d) expected none", write_x_pos, write_y_pos);
          end else begin
            e = exp_q.pop_front();
            n_checks--;
            chk("write x", int'(write_x_pos), int'(e.x));
            chk("write y", int'(write_y_pos), int'(e.y));
            chk("write color", int'(write_color), int'(e.color));
          end
          got_q.push_back({write_x_pos, write_y_pos, write_color});
        end
      end
      prev_stall = wr_valid && !wr_ready;
      held = {write_x_pos, write_y_pos, write_color};
    end
  end

  initial begin
    int dx, dy;
    repeat (2) @(negedge clk);
    chk("reset wr_valid", int'(wr_valid), 0);
    chk("reset running", int'(running), 0);
    chk("reset done", int'(done), 0);
    chk("reset x", int'(write_x_pos), 0);
    chk("reset y", int'(write_y_pos), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    model(28, 7, 20, 17, 8'hFF, 1'b1);
    chk("model line1 size", exp_q.size(), 21);
    chk("model line1 first x", int'(exp_q[0].x), 28);
    chk("model line1 last y", int'(exp_q[20].y), 24);
    run_line(28, 7, 20, 17, 8'hFF, 1'b1);
    chk("line1 writes", got_q.size(), 21);
    if (got_q.size() == 21) begin
      chk("line1 first", {int'(got_q[0].x), int'(got_q[0].y)} == {32'd28, 32'd7}, 1);
      chk("line1 last", {int'(got_q[20].x), int'(got_q[20].y)} == {32'd48, 32'd24}, 1);
    end
    for (int j = 1; j < got_q.size(); j++)
      chk("line1 x step", int'(got_q[j].x) - int'(got_q[j-1].x), 1);

    model(12, 15, 10, -4, 8'hFF, 1'b1);
    chk("model line2 last y", int'(exp_q[exp_q.size()-1].y), 11);
    run_line(12, 15, 10, -4, 8'hFF, 1'b1);
    chk("line2 writes", got_q.size(), 11);
    for (int j = 1; j < got_q.size(); j++)
      chk("line2 y nonincreasing", int'(got_q[j].y <= got_q[j-1].y), 1);

    model(150, 100, 20, 0, 8'hFF, 1'b0);
    chk("model clip size", exp_q.size(), 10);
    run_line(150, 100, 20, 0, 8'hFF, 1'b0);
    chk("clip writes", got_q.size(), 10);

    model(0, 0, 15, 0, 8'b0000_1111, 1'b1);
    chk("model dash size", exp_q.size(), 8);
    chk("model dash fifth x", int'(exp_q[4].x), 8);
    run_line(0, 0, 15, 0, 8'b0000_1111, 1'b1);
    chk("dash writes", got_q.size(), 8);

    rnd_ready = 1;
    run_line(28, 7, 20, 17, 8'hFF, 1'b1);
    chk("line1 backpressure writes", got_q.size(), 21);

    rnd_ready = 0;
    run_line(5, 5, 0, 0, 8'hFF, 1'b1);
    chk("zero length writes", got_q.size(), 1);
    if (got_q.size() == 1) chk("zero length point", int'(got_q[0].x) * 1000 + int'(got_q[0].y), 5005);

    launch(0, 0, 4, 0, 8'hFF, 1'b1);
    finish_line(1);
    chk("start while running ignored", got_q.size(), 5);

    rnd_ready = 1;
    run_line(100, 60, -256, 255, 8'hFF, 1'b1);
    for (int n = 0; n < 10; n++) begin
      dx = int'($urandom_range(0, 511)) - 256;
      dy = int'($urandom_range(0, 511)) - 256;
      run_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), dx, dy,
               8'($urandom), 1'($urandom));
    end

    rnd_ready = 0;
    launch(28, 7, 20, 17, 8'hFF, 1'b1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    #1;
    chk("abort drops valid", int'(wr_valid), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("abort no valid", int'(wr_valid), 0);
      chk("abort no done", int'(done), 0);
      chk("abort idle", int'(running), 0);
    end
    exp_q.delete();

    launch(28, 7, 20, 17, 8'hFF, 1'b1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", int'(wr_valid), 0);
    chk("async reset running", int'(running), 0);
    chk("async reset x", int'(write_x_pos), 0);
    chk("async reset y", int'(write_y_pos), 0);
    chk("async reset color", int'(write_color), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("post reset no valid", int'(wr_valid), 0);
      chk("post reset idle", int'(running), 0);
    end
    exp_q.delete();

    run_line(50, 50, -7, 9, 8'hFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
